// File: rtl/adder_issue_collect_pkg.sv
// Shared definitions for the adder issue/collect wrapper and its pipelined adder core.
// Core latency and default widths live here so the wrapper and the core cannot disagree.
package adder_issue_collect_pkg;

   localparam int ADDER_LATENCY = 3;
   localparam int DEF_WIDTH     = 32;
   localparam int DEF_TAG_W     = 4;
   localparam int DEF_DEPTH     = 4;

   typedef struct packed {
      logic zero;
      logic neg;
   } flags_t;

endpackage

// File: rtl/adder_issue_collect_if.sv
// Request/response handshake bundle for adder_issue_collect.
// The slave modport is the wrapper's view; the master modport is the requester/consumer view.
interface adder_issue_collect_if
   import adder_issue_collect_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
) ();

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_a;
   logic [WIDTH-1:0] s_b;
   logic             s_sub;
   logic             s_cin;
   logic [TAG_W-1:0] s_tag;

   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_sum;
   logic [TAG_W-1:0] m_tag;
   logic             m_zero;
   logic             m_neg;

   modport slave (
      input  s_valid, s_a, s_b, s_sub, s_cin, s_tag, m_ready,
      output s_ready, m_valid, m_sum, m_tag, m_zero, m_neg
   );

   modport master (
      output s_valid, s_a, s_b, s_sub, s_cin, s_tag, m_ready,
      input  s_ready, m_valid, m_sum, m_tag, m_zero, m_neg
   );

endinterface

// File: rtl/adder_issue_collect_result_fifo.sv
// Circular result FIFO with occupancy count; push and pop may coincide at any occupancy.
// Storage is not reset: only pointers and count are control state.
module adder_issue_collect_result_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 wdata,
   input  logic                         pop,
   output logic [W-1:0]                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipelined_adder_core.sv
// Fixed-latency adder with no stall and no reset: sum and valid appear LATENCY cycles after v_in.
// Any stale valid left in the pipe after reset drains on its own within LATENCY cycles.
module pipelined_adder_core
   import adder_issue_collect_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = ADDER_LATENCY
) (
   input  logic             clk,
   input  logic             v_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             v_out,
   output logic [WIDTH-1:0] sum
);

   logic             vld_p [LATENCY];
   logic [WIDTH-1:0] sum_p [LATENCY];

   always_ff @(posedge clk) begin
      vld_p[0] <= v_in;
      sum_p[0] <= a + b + WIDTH'(cin);
      for (int i = 1; i < LATENCY; i++) begin
         vld_p[i] <= vld_p[i-1];
         sum_p[i] <= sum_p[i-1];
      end
   end

   assign v_out = vld_p[LATENCY-1];
   assign sum   = sum_p[LATENCY-1];

endmodule

// File: rtl/adder_issue_collect.sv
// Credit-gated issue into a stall-free pipelined adder, with tag tracking and a result FIFO.
// A FIFO slot is reserved for every operation in flight, so the core never needs to stall.
module adder_issue_collect
   import adder_issue_collect_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = ADDER_LATENCY,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adder_issue_collect_if.slave bus,
   output logic                 core_v_in,
   output logic [WIDTH-1:0]     core_a,
   output logic [WIDTH-1:0]     core_b,
   output logic                 core_cin,
   input  logic                 core_v_out,
   input  logic [WIDTH-1:0]     core_sum,
   output logic                 err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int FL_W  = $clog2(LATENCY + 1);
   localparam int ENT_W = WIDTH + TAG_W + 2;

   logic [FL_W-1:0]  flush_cnt;
   logic             flush_done;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   used;
   logic             fifo_empty;
   logic             fifo_full;
   logic             issue;
   logic             collect;
   logic             pop;
   flags_t           flags;
   logic [ENT_W-1:0] wdata;
   logic [ENT_W-1:0] rdata;

   logic             tag_vld_p [LATENCY];
   logic [TAG_W-1:0] tag_p     [LATENCY];

   function automatic flags_t result_flags(input logic signed [WIDTH-1:0] s);
      flags_t f;
      f.zero = (s == '0);
      f.neg  = (s < 0);
      return f;
   endfunction

   // Issue stage: operand conditioning turns a - b into a + ~b + 1.
   assign flush_done = (flush_cnt == '0);
   assign issue      = bus.s_valid & bus.s_ready;
   assign core_v_in  = issue;
   assign core_a     = bus.s_a;
   assign core_b     = bus.s_sub ? ~bus.s_b : bus.s_b;
   assign core_cin   = bus.s_sub | bus.s_cin;

   // A result leaving the FIFO this cycle frees its slot for a request issued this cycle,
   // which keeps one request per cycle sustainable with DEPTH = LATENCY + 1.
   assign pop  = bus.m_valid & bus.m_ready;
   assign used = {1'b0, fifo_count} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
   assign bus.s_ready = flush_done & (used < (CNT_W + 1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= FL_W'(LATENCY);
      end else if (!flush_done) begin
         flush_cnt <= flush_cnt - FL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         case ({issue, collect})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= (inflight != '0) ? inflight - CNT_W'(1) : inflight;
            default: inflight <= inflight;
         endcase
      end
   end

   // Tag line: mirrors the core pipeline so its last stage lines up with core_v_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) tag_vld_p[i] <= 1'b0;
      end else begin
         tag_vld_p[0] <= issue;
         for (int i = 1; i < LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_p[0] <= bus.s_tag;
      for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
   end

   // Collect stage: core valids are ignored while stale results drain after reset.
   assign collect = core_v_out & flush_done;
   assign flags   = result_flags(core_sum);
   assign wdata   = {core_sum, tag_p[LATENCY-1], flags.zero, flags.neg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (collect && ((inflight == '0) || !tag_vld_p[LATENCY-1] || (fifo_full && !pop))) begin
         err <= 1'b1;
      end
   end

   adder_issue_collect_result_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) result_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (collect),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.m_valid = ~fifo_empty;
   assign {bus.m_sum, bus.m_tag, bus.m_zero, bus.m_neg} = rdata;

endmodule

// File: tb/tb_adder_issue_collect.sv
// Directed bench for adder_issue_collect paired with pipelined_adder_core.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_adder_issue_collect;
   import adder_issue_collect_pkg::*;

   typedef struct packed {
      logic [31:0] sum;
      logic [3:0]  tag;
      logic        zero;
      logic        neg;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        core_v_in;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic        core_cin;
   logic        core_v_out;
   logic [31:0] core_sum;
   logic        err;

   int   checks = 0;
   int   errors = 0;
   res_t got_q[$];

   adder_issue_collect_if #(.WIDTH(32), .TAG_W(4)) bus ();

   adder_issue_collect #(
      .WIDTH(32), .LATENCY(3), .DEPTH(4), .TAG_W(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .core_v_in  (core_v_in),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_cin   (core_cin),
      .core_v_out (core_v_out),
      .core_sum   (core_sum),
      .err        (err)
   );

   pipelined_adder_core #(.WIDTH(32), .LATENCY(3)) core (
      .clk   (clk),
      .v_in  (core_v_in),
      .a     (core_a),
      .b     (core_b),
      .cin   (core_cin),
      .v_out (core_v_out),
      .sum   (core_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every result consumed by the bench.
   always @(negedge clk) begin
      #2;
      if (rst_n && bus.m_valid && bus.m_ready)
         got_q.push_back({bus.m_sum, bus.m_tag, bus.m_zero, bus.m_neg});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, input logic [3:0] tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b1; bus.s_a = a; bus.s_b = b;
         bus.s_sub = sub; bus.s_cin = cin; bus.s_tag = tag;
         #1;
         if (bus.s_ready) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            ok = 1'b1;
            return;
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_result(output res_t r, output bit ok);
      ok = 1'b0;
      r  = '0;
      for (int i = 0; i < 40; i++) begin
         if (got_q.size() > 0) begin
            r  = got_q.pop_front();
            ok = 1'b1;
            return;
         end
         @(negedge clk); #3;
      end
   endtask

   task automatic test_reset;
      int lat;
      rst_n = 1'b0;
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1; bus.s_a = 32'd5; bus.s_b = 32'd7;
      bus.s_sub = 1'b0; bus.s_cin = 1'b0; bus.s_tag = 4'd1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", bus.m_valid); end
      checks++; if (core_v_in !== 1'b0) begin errors++; $display("FAIL reset_core_v_in got %0b want 0", core_v_in); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         checks++;
         if (bus.s_ready !== 1'b0 || core_v_in !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold cycle %0d s_ready %0b core_v_in %0b want 0", k, bus.s_ready, core_v_in);
         end
      end
      @(negedge clk); #1;
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL flush_done_s_ready got %0b want 1", bus.s_ready); end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         lat++;
         if (bus.m_valid) break;
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL first_latency got %0d want 4", lat); end
      checks++; if (bus.m_sum !== 32'd12) begin errors++; $display("FAIL add_5_7_sum got %0d want 12", bus.m_sum); end
      checks++; if (bus.m_tag !== 4'd1) begin errors++; $display("FAIL add_5_7_tag got %0d want 1", bus.m_tag); end
      checks++; if (bus.m_zero !== 1'b0 || bus.m_neg !== 1'b0) begin errors++; $display("FAIL add_5_7_flags got z%0b n%0b want z0 n0", bus.m_zero, bus.m_neg); end
      @(negedge clk); #3;
      got_q.delete();
   endtask

   task automatic test_sub;
      res_t r; bit ok;
      send(32'd5, 32'd5, 1'b1, 1'b0, 4'd2, ok);
      wait_result(r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sub_5_5_timeout got none want result"); end
      checks++; if (r.sum !== 32'd0 || r.zero !== 1'b1 || r.neg !== 1'b0 || r.tag !== 4'd2) begin
         errors++; $display("FAIL sub_5_5 got sum %h z%0b n%0b tag %0d want 0 z1 n0 tag 2", r.sum, r.zero, r.neg, r.tag); end
      send(32'd3, 32'd5, 1'b1, 1'b0, 4'd3, ok);
      wait_result(r, ok);
      checks++; if (r.sum !== 32'hFFFF_FFFE || r.neg !== 1'b1 || r.zero !== 1'b0 || r.tag !== 4'd3) begin
         errors++; $display("FAIL sub_3_5 got sum %h z%0b n%0b tag %0d want fffffffe z0 n1 tag 3", r.sum, r.zero, r.neg, r.tag); end
      send(32'd10, 32'd20, 1'b0, 1'b1, 4'd4, ok);
      wait_result(r, ok);
      checks++; if (r.sum !== 32'd31 || r.tag !== 4'd4) begin
         errors++; $display("FAIL add_cin got sum %0d tag %0d want 31 tag 4", r.sum, r.tag); end
   endtask

   task automatic test_wrap;
      res_t r; bit ok;
      send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd9, ok);
      wait_result(r, ok);
      checks++; if (r.sum !== 32'd0 || r.zero !== 1'b1 || r.neg !== 1'b0) begin
         errors++; $display("FAIL wrap got sum %h z%0b n%0b want 0 z1 n0", r.sum, r.zero, r.neg); end
      checks++; if (r.tag !== 4'd9) begin errors++; $display("FAIL wrap_tag got %0d want 9", r.tag); end
   endtask

   task automatic test_backpressure;
      int acc;
      int cyc;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.m_ready = 1'b0;
         bus.s_valid = 1'b1; bus.s_a = 32'(acc); bus.s_b = 32'd100;
         bus.s_sub = 1'b0; bus.s_cin = 1'b0; bus.s_tag = 4'(acc);
         #1;
         if (bus.s_ready) acc++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
      repeat (4) @(negedge clk);
      #1;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_held got %0b want 0", bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b1 || bus.m_tag !== 4'd0) begin
         errors++; $display("FAIL bp_head got valid %0b tag %0d want valid 1 tag 0", bus.m_valid, bus.m_tag); end
      cyc = 0;
      while (acc < 10 && cyc < 40) begin
         @(negedge clk);
         bus.m_ready = 1'b1;
         bus.s_valid = 1'b1; bus.s_a = 32'(acc); bus.s_b = 32'd100;
         bus.s_tag = 4'(acc);
         #1;
         if (bus.s_ready) acc++;
         cyc++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      checks++; if (acc !== 10) begin errors++; $display("FAIL bp_resume got %0d want 10", acc); end
      for (int i = 0; i < 40 && got_q.size() < 10; i++) begin @(negedge clk); #3; end
      checks++; if (got_q.size() !== 10) begin errors++; $display("FAIL bp_count got %0d want 10", got_q.size()); end
      for (int i = 0; i < 10 && got_q.size() > 0; i++) begin
         res_t r;
         r = got_q.pop_front();
         checks++;
         if (r.tag !== 4'(i) || r.sum !== 32'(i + 100)) begin
            errors++; $display("FAIL bp_order idx %0d got tag %0d sum %0d want tag %0d sum %0d", i, r.tag, r.sum, i, i + 100);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ra [100];
      logic [31:0] rb [100];
      logic        rs [100];
      logic        rc [100];
      res_t        exp_q[$];
      int          idx, cyc, drops;
      for (int i = 0; i < 100; i++) begin
         ra[i] = $urandom(); rb[i] = $urandom();
         rs[i] = 1'($urandom_range(0, 1)); rc[i] = 1'($urandom_range(0, 1));
         if (i == 7) begin ra[i] = 32'h8000_0000; rb[i] = 32'h8000_0000; rs[i] = 1'b0; rc[i] = 1'b0; end
         if (i == 8) begin ra[i] = 32'd77; rb[i] = 32'd77; rs[i] = 1'b1; rc[i] = 1'b1; end
      end
      got_q.delete();
      idx = 0; cyc = 0; drops = 0;
      while (idx < 100 && cyc < 400) begin
         @(negedge clk);
         bus.m_ready = 1'b1;
         bus.s_valid = 1'b1; bus.s_a = ra[idx]; bus.s_b = rb[idx];
         bus.s_sub = rs[idx]; bus.s_cin = rc[idx]; bus.s_tag = 4'(idx);
         #1;
         if (bus.s_ready) begin
            res_t e;
            e.sum  = rs[idx] ? (ra[idx] - rb[idx]) : (ra[idx] + rb[idx] + 32'(rc[idx]));
            e.tag  = 4'(idx);
            e.zero = (e.sum == 32'd0);
            e.neg  = e.sum[31];
            exp_q.push_back(e);
            idx++;
         end else begin
            drops++;
         end
         cyc++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      checks++; if (drops !== 0) begin errors++; $display("FAIL stream_s_ready_drops got %0d want 0", drops); end
      for (int i = 0; i < 40 && got_q.size() < 100; i++) begin @(negedge clk); #3; end
      checks++; if (got_q.size() !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g, e;
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin
            errors++; $display("FAIL stream_result got sum %h tag %0d z%0b n%0b want sum %h tag %0d z%0b n%0b",
                               g.sum, g.tag, g.zero, g.neg, e.sum, e.tag, e.zero, e.neg);
         end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err got %0b want 0", err); end
   endtask

   task automatic test_mid_reset;
      int acc, cyc;
      res_t r; bit ok;
      acc = 0; cyc = 0;
      while (acc < 4 && cyc < 20) begin
         @(negedge clk);
         bus.m_ready = 1'b0;
         bus.s_valid = 1'b1; bus.s_a = 32'(acc + 1); bus.s_b = 32'd1;
         bus.s_sub = 1'b0; bus.s_cin = 1'b0; bus.s_tag = 4'(acc);
         #1;
         if (bus.s_ready) acc++;
         cyc++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      #1;
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %0b want 1", bus.m_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_async got m_valid %0b s_ready %0b want 0 0", bus.m_valid, bus.s_ready); end
      repeat (2) @(negedge clk);
      got_q.delete();
      bus.m_ready = 1'b1;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #3;
      checks++; if (got_q.size() !== 0 || bus.m_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_stale got %0d results m_valid %0b want 0 0", got_q.size(), bus.m_valid); end
      send(32'd20, 32'd22, 1'b0, 1'b0, 4'd5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_issue got no accept want accept"); end
      wait_result(r, ok);
      checks++; if (!ok || r.sum !== 32'd42 || r.tag !== 4'd5) begin
         errors++; $display("FAIL midrst_next got sum %0d tag %0d want 42 tag 5", r.sum, r.tag); end
      repeat (6) @(negedge clk);
      #3;
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_extra got %0d want 0", got_q.size()); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %0b want 0", err); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0;
      bus.s_sub = 1'b0; bus.s_cin = 1'b0; bus.s_tag = '0;
      bus.m_ready = 1'b1;
      test_reset();
      test_sub();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
